// File: rtl/spindash_i2s_tx_if.sv
// Sample-in / I2S-out bundle for spindash_i2s_tx.
// master = mix producer and DAC side, slave = the serializer.
interface spindash_i2s_tx_if #(
  parameter int WIDTH = 20
);
  logic signed [WIDTH-1:0] snd_left;
  logic signed [WIDTH-1:0] snd_right;
  logic                    snd_sample;
  logic                    status_clr;
  logic                    i2s_bclk;
  logic                    i2s_lrck;
  logic                    i2s_sd;
  logic                    frame_start;
  logic                    underrun;
  logic                    overrun;

  modport master (
    output snd_left, snd_right, snd_sample, status_clr,
    input  i2s_bclk, i2s_lrck, i2s_sd, frame_start, underrun, overrun
  );

  modport slave (
    input  snd_left, snd_right, snd_sample, status_clr,
    output i2s_bclk, i2s_lrck, i2s_sd, frame_start, underrun, overrun
  );
endinterface

// File: rtl/spindash_i2s_tx.sv
// Double-buffered Philips I2S transmitter for the spindash FM mix.
// Define SPINDASH_I2S_SAT_EN to saturate (instead of wrap) after GAIN.
module spindash_i2s_tx #(
  parameter int WIDTH     = 20,
  parameter int OUT_BITS  = 24,
  parameter int BCLK_HALF = 9,
  parameter int GAIN      = 0
) (
  input logic              clk,
  input logic              rst,
  spindash_i2s_tx_if.slave bus
);
  localparam int EXT_W = OUT_BITS + GAIN;
  localparam int SHIFT = OUT_BITS - WIDTH + GAIN;
  localparam int FRAME = 2 * OUT_BITS;
  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int B_W   = $clog2(FRAME);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [B_W-1:0]   B_LAST   = B_W'(FRAME - 1);
  localparam logic [B_W-1:0]   LR_FIRST = B_W'(OUT_BITS - 1);
  localparam logic [B_W-1:0]   LR_LAST  = B_W'(FRAME - 2);

  logic [DIV_W-1:0]    div_cnt, div_cnt_nx;
  logic [B_W-1:0]      b, b_nx;
  logic                bclk, bclk_nx, lrck, lrck_nx, sd, sd_nx;
  logic                snd_sample_d, capture, div_wrap, bclk_fall, load;
  logic                pending, pending_nx;
  logic                underrun, underrun_nx, overrun, overrun_nx;
  logic                frame_start;
  logic [OUT_BITS-1:0] hold_l, hold_r, hold_l_nx, hold_r_nx;
  logic [FRAME-1:0]    shifter, shifter_nx;

  function automatic logic [OUT_BITS-1:0] convert(input logic signed [WIDTH-1:0] s);
`ifdef SPINDASH_I2S_SAT_EN
    logic signed [EXT_W-1:0] ext;
    ext = EXT_W'(s);
    ext = ext <<< SHIFT;
    if (ext[EXT_W-1:OUT_BITS-1] != {(GAIN+1){ext[EXT_W-1]}})
      return ext[EXT_W-1] ? {1'b1, {(OUT_BITS-1){1'b0}}} : {1'b0, {(OUT_BITS-1){1'b1}}};
    return ext[OUT_BITS-1:0];
`else
    logic [OUT_BITS-1:0] wide;
    wide = OUT_BITS'(s);
    return wide << SHIFT;
`endif
  endfunction

  always_comb begin
    capture    = bus.snd_sample & ~snd_sample_d;
    div_wrap   = (div_cnt == DIV_LAST);
    bclk_fall  = div_wrap & bclk;
    load       = bclk_fall & (b == B_LAST);

    div_cnt_nx = div_wrap ? '0 : div_cnt + 1'b1;
    bclk_nx    = div_wrap ? ~bclk : bclk;
    b_nx       = b;
    sd_nx      = sd;
    lrck_nx    = lrck;
    shifter_nx = shifter;

    // Shifter holds the bits still to be sent; the MSB of the new left word
    // goes straight to sd on the load edge.
    if (bclk_fall) begin
      b_nx = load ? '0 : b + 1'b1;
      if (load) begin
        sd_nx      = hold_l[OUT_BITS-1];
        shifter_nx = {hold_l[OUT_BITS-2:0], hold_r, 1'b0};
      end else begin
        sd_nx      = shifter[FRAME-1];
        shifter_nx = shifter << 1;
      end
      lrck_nx = (b_nx >= LR_FIRST) && (b_nx <= LR_LAST);
    end

    // Load reads the old holding words while a coincident capture overwrites them.
    hold_l_nx = hold_l;
    hold_r_nx = hold_r;
    if (capture) begin
      hold_l_nx = convert(bus.snd_left);
      hold_r_nx = convert(bus.snd_right);
    end
    pending_nx  = capture | (pending & ~load);
    underrun_nx = (load & ~pending & ~capture) | (underrun & ~bus.status_clr);
    overrun_nx  = (capture & pending & ~load) | (overrun & ~bus.status_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      b            <= '0;
      bclk         <= 1'b0;
      lrck         <= 1'b0;
      sd           <= 1'b0;
      snd_sample_d <= 1'b0;
      pending      <= 1'b0;
      underrun     <= 1'b0;
      overrun      <= 1'b0;
      frame_start  <= 1'b0;
      hold_l       <= '0;
      hold_r       <= '0;
      shifter      <= '0;
    end else begin
      div_cnt      <= div_cnt_nx;
      b            <= b_nx;
      bclk         <= bclk_nx;
      lrck         <= lrck_nx;
      sd           <= sd_nx;
      snd_sample_d <= bus.snd_sample;
      pending      <= pending_nx;
      underrun     <= underrun_nx;
      overrun      <= overrun_nx;
      frame_start  <= load;
      hold_l       <= hold_l_nx;
      hold_r       <= hold_r_nx;
      shifter      <= shifter_nx;
    end
  end

  assign bus.i2s_bclk    = bclk;
  assign bus.i2s_lrck    = lrck;
  assign bus.i2s_sd      = sd;
  assign bus.frame_start = frame_start;
  assign bus.underrun    = underrun;
  assign bus.overrun     = overrun;
endmodule

// File: doc/spindash_i2s_tx.md
# spindash_i2s_tx

Serial audio output stage for the summed FM mix. It consumes the signed left/right mix words and the new-sample strobe produced by the spindash top level, all in the master clock domain. Each strobed sample pair is double-buffered and shifted out as a Philips-format I2S stream (BCLK, LRCK, SD) for an external DAC. It provides the I2S output path alongside the existing PDM outputs.

## Interface
- WIDTH, 20, width of signed input samples (16 + clog2(chip count))
- OUT_BITS, 24, bits per I2S slot; must be >= WIDTH
- BCLK_HALF, 9, clk cycles per BCLK half-period (864 clk/sample = 2*OUT_BITS*2*BCLK_HALF)
- GAIN, 0, left shift (0..7) applied after MSB alignment
- clk  in  1  master clock (clk_jt, 53.7037 MHz); one clock, no other domains
- rst  in  1  reset; synchronous, active-high
- snd_left  in  WIDTH  signed left mix
- snd_right  in  WIDTH  signed right mix
- snd_sample  in  1  new-sample indicator; rising edge marks valid snd_left/snd_right
- status_clr  in  1  clears underrun/overrun when high for one clk
- i2s_bclk  out  1  bit clock
- i2s_lrck  out  1  word select (0 = left)
- i2s_sd  out  1  serial data, MSB first
- frame_start  out  1  1-clk pulse on the clk where the frame shift registers load
- underrun  out  1  sticky: frame loaded with no new sample pending
- overrun  out  1  sticky: new sample captured while previous still pending

## Operation
- Edge detect: snd_sample_d registered each clk; capture = snd_sample & ~snd_sample_d. On capture, snd_left/snd_right of that clk go into the holding registers and pending is set.
- Conversion at capture: value = sample sign-extended to OUT_BITS+GAIN bits, shifted left by (OUT_BITS-WIDTH+GAIN), then reduced to OUT_BITS (see Configuration).
- Divider: div_cnt counts 0..BCLK_HALF-1; on wrap, i2s_bclk toggles. A 1->0 toggle (falling edge) advances bit index b (0..2*OUT_BITS-1, wraps to 0).
- Frame load: on the falling edge where b wraps to 0, the holding registers are copied into the left/right shift registers, pending is cleared, and frame_start pulses.
- Bit period b (falling edge to falling edge): i2s_sd = left[OUT_BITS-1-b] for b < OUT_BITS, else right[2*OUT_BITS-1-b]. i2s_lrck = 1 for b in [OUT_BITS-1, 2*OUT_BITS-2], else 0 (one-BCLK-early I2S word select).
- Underrun: frame load with pending = 0 sets underrun; the previous holding contents are re-sent.
- Overrun: capture with pending = 1 sets overrun; new data overwrites holding.
- Capture and frame load in the same clk: the load takes the old holding contents and the capture writes the new contents. Pending ends at 1. No overrun and no underrun are flagged, even if pending was 0 before.
- status_clr clears both sticky flags. A set event in the same clk wins.

## Timing
- Reset values: i2s_bclk=0, i2s_lrck=0, i2s_sd=0, frame_start=0, underrun=0, overrun=0, div_cnt=0, b=0, holding/shift=0, pending=0, snd_sample_d=0.
- The first BCLK rising edge occurs BCLK_HALF clks after rst deasserts. The first falling edge, and b=1, occurs at 2*BCLK_HALF. The first frame load occurs at 2*OUT_BITS*2*BCLK_HALF clks (864 at defaults).
- i2s_sd and i2s_lrck change only in the clk of a BCLK falling edge, so they are stable across the rising edge.
- Capture-to-first-SD-bit latency is variable, at most one frame plus 1 clk. The stream is free-running and is not phase-locked to snd_sample.
- All outputs are registered; no combinational path runs from inputs to outputs.
- rst mid-frame returns every output and counter to its reset value on the next clk edge, truncating the frame.

## Configuration
- SPINDASH_I2S_SAT_EN
  - Defined: the shifted value is saturated to the signed OUT_BITS range, i.e. [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
  - Undefined: the upper bits are discarded, giving two's-complement wrap. GAIN=0 is then always lossless, and the saturation logic is removed.

## Test plan
- Defaults, reset then capture L=0x7FFFF, R=0xFFFFF (-1) -> next frame SD = 0x7FFFF0 (left, MSB first), 0xFFFFF0 (right); LRCK low for b=0..22 and b=47, high for b=23..46; BCLK period 18 clk.
- No snd_sample for two frames after one capture -> the same words are repeated; underrun=1 after the second load; status_clr -> 0.
- Two rising edges of snd_sample within one frame (L=0x00001 then L=0x00002) -> overrun=1; next frame left word = 0x000020.
- Capture coincident with the frame-load clk -> the loaded frame carries the old data, the following frame carries the new data; neither flag is set.
- GAIN=2, L=0x40000 -> with SPINDASH_I2S_SAT_EN, left word = 0x7FFFFF; without it, left word = 0x000000.
- rst asserted at b=30 for 1 clk -> next clk all outputs 0; the first frame_start occurs exactly 864 clks after rst deasserts.
